// File: rtl/ic74hc74_if.sv
// Data/output bundle for the ic74hc74 flop bank: d in, true and complement out.
interface ic74hc74_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_;

  modport master (output d, input q, q_);
  modport slave  (input d, output q, q_);
endinterface

// File: rtl/ic74hc74.sv
// Bank of WIDTH positive-edge D flops with shared synchronous clear and
// complementary outputs (one 74HC74 section per bit, no preset).
module ic74hc74_bit (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);
  // Clear wins over d at the same edge.
  always_ff @(posedge clk) begin
    if (clr) q <= 1'b0;
    else     q <= d;
  end
endmodule

module ic74hc74 #(parameter int WIDTH = 1) (
  input  logic         clk,
  input  logic         clr,
  ic74hc74_if.slave    bus
);
  logic [WIDTH-1:0] state;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ic74hc74_bit u_bit (
      .clk (clk),
      .clr (clr),
      .d   (bus.d[i]),
      .q   (state[i])
    );
  end

  // q_ derived from the same register so q and q_ can never agree.
  assign bus.q  = state;
  assign bus.q_ = ~state;
endmodule

// File: tb/tb_ic74hc74.sv
// Scoreboard bench for ic74hc74 (WIDTH=4): driver pushes expected q per edge,
// monitor pops and compares just after each rising edge.
module tb_ic74hc74;
  localparam int W = 4;

  logic clk = 1'b0;
  logic clr;
  ic74hc74_if #(.WIDTH(W)) bus ();

  ic74hc74 #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int total  = 0;
  int passed = 0;
  logic [W-1:0] expq[$];
  logic [W-1:0] model;
  bit           model_ok = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
  endtask

  // Apply one vector on the low phase; outputs must not move before the edge.
  task automatic step(input logic [W-1:0] dv, input logic cv);
    bus.d = dv;
    clr   = cv;
    if (model_ok) begin
      #1;
      chk("hold_q", bus.q, model);
      chk("hold_qn", bus.q_, ~model);
    end
    model    = cv ? '0 : dv;
    model_ok = 1'b1;
    expq.push_back(model);
    @(negedge clk);
  endtask

  // Toggle d several times while clk is low, then settle on dv.
  task automatic wiggle(input logic [W-1:0] dv);
    logic [W-1:0] pat [4];
    pat[0] = ~dv; pat[1] = 4'b1111; pat[2] = 4'b0000; pat[3] = 4'b0110;
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.d = pat[k];
      #1;
      chk("no_transp", bus.q, model);
    end
    step(dv, 1'b0);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        logic [W-1:0] e;
        e = expq.pop_front();
        chk("q", bus.q, e);
        chk("qn", bus.q_, ~e);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    clr   = 1'b1;
    bus.d = '0;
    // reset, and clear holds with d=1
    step(4'b0000, 1'b1);
    step(4'b1111, 1'b1);
    // load 1 and keep it
    step(4'b0000, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    // clear while set, held
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    // release with d=1, then d->0
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);
    // no transparency
    wiggle(4'b1010);
    wiggle(4'b0101);
    // bit independence and complement
    step(4'b1010, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b1100, 1'b1);
    step(4'b0110, 1'b0);
    step(4'b1001, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (expq.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", expq.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
